// File: rtl/plab4_net_domain_chan.sv
// Domain-separated inter-router channel stage.
// Splits one tagged val/rdy stream into p_num_domains independent FIFOs of
// depth p_depth. Each domain has its own val/rdy output, free-slot count and
// flush. Messages carrying an out-of-range domain are accepted, dropped and
// flagged with a one-cycle err_bad_domain pulse.
//
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   in_val/in_rdy          upstream handshake
//   in_domain              domain tag of the incoming message
//   in_msg_control/_data   incoming message fields
//   out_val/out_rdy        per-domain downstream handshake
//   out_msg_control/_data  per-domain head message, domain d at [d*W +: W]
//   num_free               per-domain free-slot count, domain d at [d*C +: C]
//   flush                  per-domain synchronous queue clear
//   err_bad_domain         pulse: invalid-domain message was dropped
module plab4_net_domain_chan #(
   parameter  int unsigned p_msg_cnbits   = 38,
   parameter  int unsigned p_msg_dnbits   = 32,
   parameter  int unsigned p_num_domains  = 2,
   parameter  int unsigned p_domain_nbits = 1,
   parameter  int unsigned p_depth        = 2,
   localparam int unsigned c_cnt_nbits    = $clog2(p_depth + 1)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   in_val,
   output logic                                   in_rdy,
   input  logic [p_domain_nbits-1:0]              in_domain,
   input  logic [p_msg_cnbits-1:0]                in_msg_control,
   input  logic [p_msg_dnbits-1:0]                in_msg_data,
   output logic [p_num_domains-1:0]               out_val,
   input  logic [p_num_domains-1:0]               out_rdy,
   output logic [p_num_domains*p_msg_cnbits-1:0]  out_msg_control,
   output logic [p_num_domains*p_msg_dnbits-1:0]  out_msg_data,
   output logic [p_num_domains*c_cnt_nbits-1:0]   num_free,
   input  logic [p_num_domains-1:0]               flush,
   output logic                                   err_bad_domain
);

   localparam int unsigned c_ptr_nbits = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam logic [c_cnt_nbits-1:0] c_depth_cnt = c_cnt_nbits'(p_depth);
   localparam logic [c_ptr_nbits-1:0] c_last_ptr  = c_ptr_nbits'(p_depth - 1);

   typedef struct packed {
      logic [p_msg_cnbits-1:0] ctrl;
      logic [p_msg_dnbits-1:0] data;
   } msg_t;

   msg_t                   mem_q  [p_num_domains][p_depth];
   logic [c_ptr_nbits-1:0] head_q [p_num_domains];
   logic [c_ptr_nbits-1:0] head_d [p_num_domains];
   logic [c_ptr_nbits-1:0] tail_q [p_num_domains];
   logic [c_ptr_nbits-1:0] tail_d [p_num_domains];
   logic [c_cnt_nbits-1:0] cnt_q  [p_num_domains];
   logic [c_cnt_nbits-1:0] cnt_d  [p_num_domains];
   logic                   err_q;
   logic                   err_d;
   logic                   dom_ok_c;
   logic [p_num_domains-1:0] enq_c;
   logic [p_num_domains-1:0] deq_c;

   function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] p);
      return (p == c_last_ptr) ? '0 : p + c_ptr_nbits'(1);
   endfunction

   assign dom_ok_c = (32'(in_domain) < p_num_domains);

   // Ready looks only at the selected domain's occupancy; invalid domains are always accepted.
   always_comb begin
      in_rdy = 1'b1;
      for (int d = 0; d < int'(p_num_domains); d++) begin
         if (32'(in_domain) == 32'(d)) in_rdy = (cnt_q[d] != c_depth_cnt);
      end
   end

   // Per-domain handshakes and next-state; flush overrides both enqueue and dequeue.
   always_comb begin
      err_d = in_val && !dom_ok_c;
      for (int d = 0; d < int'(p_num_domains); d++) begin
         enq_c[d]  = 1'b0;
         deq_c[d]  = 1'b0;
         head_d[d] = head_q[d];
         tail_d[d] = tail_q[d];
         cnt_d[d]  = cnt_q[d];
         enq_c[d]  = in_val && in_rdy && (32'(in_domain) == 32'(d)) && !flush[d];
         deq_c[d]  = (cnt_q[d] != '0) && out_rdy[d] && !flush[d];
         if (flush[d]) begin
            head_d[d] = '0;
            tail_d[d] = '0;
            cnt_d[d]  = '0;
         end else begin
            if (enq_c[d]) tail_d[d] = ptr_inc(tail_q[d]);
            if (deq_c[d]) head_d[d] = ptr_inc(head_q[d]);
            cnt_d[d] = cnt_q[d] + c_cnt_nbits'(enq_c[d]) - c_cnt_nbits'(deq_c[d]);
         end
      end
   end

   // Pointer, occupancy and error-pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int d = 0; d < int'(p_num_domains); d++) begin
            head_q[d] <= '0;
            tail_q[d] <= '0;
            cnt_q[d]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int d = 0; d < int'(p_num_domains); d++) begin
            head_q[d] <= head_d[d];
            tail_q[d] <= tail_d[d];
            cnt_q[d]  <= cnt_d[d];
         end
         err_q <= err_d;
      end
   end

   // Message storage; contents are don't-care while a slot is unoccupied.
   always_ff @(posedge clk) begin
      for (int d = 0; d < int'(p_num_domains); d++) begin
         if (enq_c[d]) mem_q[d][tail_q[d]] <= '{ctrl: in_msg_control, data: in_msg_data};
      end
   end

   // Outputs from registered state; empty queues expose zeros rather than stale data.
   always_comb begin
      out_val         = '0;
      out_msg_control = '0;
      out_msg_data    = '0;
      num_free        = '0;
      for (int d = 0; d < int'(p_num_domains); d++) begin
         out_val[d] = (cnt_q[d] != '0);
         num_free[d*c_cnt_nbits +: c_cnt_nbits] = c_depth_cnt - cnt_q[d];
         if (cnt_q[d] != '0) begin
            out_msg_control[d*p_msg_cnbits +: p_msg_cnbits] = mem_q[d][head_q[d]].ctrl;
            out_msg_data[d*p_msg_dnbits +: p_msg_dnbits]    = mem_q[d][head_q[d]].data;
         end
      end
   end

   assign err_bad_domain = err_q;

endmodule

// File: doc/plab4_net_domain_chan.md
Name: plab4_net_domain_chan

Overview:
- Parametrised, domain-separated inter-router channel stage for the ring network, placed on each forward and backward link between adjacent routers.
- Accepts one tagged val/rdy message stream from the upstream router output port.
- Demultiplexes the stream by security domain into p_num_domains independent FIFOs of depth p_depth, and presents one val/rdy output per domain to the downstream router.
- Generalises the fixed two-domain combinational demux to N domains with buffering, per-domain free-slot counts (for adaptive routing), per-domain flush, and invalid-domain rejection.

Parameters:
- p_msg_cnbits, 38: control (header) message width.
- p_msg_dnbits, 32: data payload width.
- p_num_domains, 2: number of security domains/queues (>=1).
- p_domain_nbits, 1: width of the domain index; must satisfy 2^p_domain_nbits >= p_num_domains.
- p_depth, 2: entries per domain queue (>=1).
- c_cnt_nbits, $clog2(p_depth+1): width of the free-slot count; derived, not set externally.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_val  in  1  upstream message valid.
- in_rdy  out  1  upstream ready.
- in_domain  in  p_domain_nbits  domain index of the incoming message.
- in_msg_control  in  p_msg_cnbits  incoming control field.
- in_msg_data  in  p_msg_dnbits  incoming data field.
- out_val  out  p_num_domains  per-domain head valid.
- out_rdy  in  p_num_domains  per-domain downstream ready.
- out_msg_control  out  p_num_domains*p_msg_cnbits  per-domain head control; domain d occupies bits [d*cnbits +: cnbits].
- out_msg_data  out  p_num_domains*p_msg_dnbits  per-domain head data; same packing as out_msg_control.
- num_free  out  p_num_domains*c_cnt_nbits  per-domain free-slot count.
- flush  in  p_num_domains  per-domain synchronous queue clear.
- err_bad_domain  out  1  one-cycle pulse when a message carrying in_domain >= p_num_domains is accepted and dropped.

Behaviour:
- Reset (reset==0, asynchronous):
  - All head/tail pointers and occupancy counts clear to 0.
  - out_val = 0, num_free = p_depth per domain, err_bad_domain = 0.
  - Storage contents need not be cleared.
- Queue organisation:
  - One circular FIFO per domain: head pointer, tail pointer, occupancy count of width c_cnt_nbits.
  - Pointers wrap from p_depth-1 to 0. With p_depth==1, pointers stay at 0.
- in_rdy:
  - = !full[in_domain] when in_domain < p_num_domains; = 1 otherwise.
  - Depends only on the selected domain's occupancy. It never depends on out_rdy or on any other domain's state (no cross-domain backpressure and no combinational in/out path).
- Enqueue:
  - Occurs on in_val && in_rdy && valid domain. Message is written at tail[in_domain], tail increments, count increments.
  - Invalid domain: message is consumed and dropped; err_bad_domain = 1 on the next cycle only (registered).
- Dequeue for domain d:
  - Occurs on out_val[d] && out_rdy[d]. Head increments, count decrements.
- Latency and bypass:
  - No bypass. A message enqueued at edge N is visible (out_val[d]=1) from cycle N+1.
  - Minimum latency is 1 cycle; full throughput is 1 msg/cycle per domain when not full.
- Full queue:
  - in_rdy for that domain = 0, even if a dequeue happens in the same cycle.
- Simultaneous enqueue and dequeue on a non-full, non-empty queue: count is unchanged and both pointers advance.
- Empty queue: out_val[d] = 0, and out_msg_control/out_msg_data for d are forced to all-zero so stale data is never exposed.
- out_val[d] = (count[d] != 0); num_free[d] = p_depth - count[d]. Both are pure functions of registered state.
- Flush:
  - flush[d] sets head = tail = count = 0 for domain d at the next edge.
  - It overrides any enqueue or dequeue to d in that cycle. The enqueue handshake still completes (in_rdy unaffected) and the message is discarded.
  - Other domains are unaffected.
- Domains operate fully independently. Simultaneous dequeues across all domains plus one enqueue are legal in the same cycle.
- Reset asserted mid-transfer: all queues empty immediately (asynchronous). Any in-flight handshake is lost; no output is valid until reset deasserts and a new enqueue occurs.

Test Plan:
1. Reset release, p_num_domains=2, p_depth=2: check out_val=2'b00, num_free={2,2}, in_rdy=1, all out_msg fields zero.
2. Enqueue ctrl=0x15/data=0xAAAA0001 to domain 1 at cycle 0 with out_rdy=0: cycle 1 shows out_val=2'b10, data slice 1 = 0xAAAA0001, num_free[1]=1, domain 0 fields still zero.
3. Fill domain 0 with 2 msgs while out_rdy[0]=0:
   - in_rdy=0 only when in_domain=0; a domain-1 message is still accepted the same cycle.
   - Raise out_rdy[0] while in_domain=0: in_rdy stays 0 that cycle, becomes 1 the next.
4. Streaming: in_val held high to domain 0, out_rdy[0]=1, 8 msgs data 1..8: outputs 1..8 in order, one per cycle after 1-cycle latency, num_free[0] stays at 1.
5. Domain 1 holds 2 msgs, then flush[1]=1 together with an enqueue to domain 1: next cycle out_val[1]=0, num_free[1]=2, enqueued msg absent, domain 0 contents unchanged.
6. p_num_domains=3, p_domain_nbits=2: in_domain=3 with in_val=1 gives in_rdy=1, err_bad_domain=1 for exactly one cycle, and no queue changes. Separately, asserting reset low with 2 msgs queued clears out_val to 0 immediately, without waiting for a clock edge.
